mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter for the xgriscv pipeline. Shares one memory bus between the IF-stage instruction fetch and the MEM-stage load/store port. Allows one outstanding transaction, routes each response back to its owner, and generates byte enables from the controller's `swhb`/`lwhb` size encoding. It also drives the per-stage stall signals the pipeline needs while its port is waiting.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (fixed 4 byte lanes)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request (level)
- `if_addr`  in  AW  fetch address, word aligned
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch data valid (one-cycle pulse)
- `if_rdata`  out  DW  fetch data
- `dm_req`  in  1  data request (level)
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  AW  byte address
- `dm_size`  in  2  11 = word, 10 = half, 01 = byte (swhb/lwhb encoding)
- `dm_wdata`  in  DW  store data, right-aligned
- `dm_gnt`  out  1  data request accepted
- `dm_rvalid`  out  1  load data or store acknowledge (pulse)
- `dm_rdata`  out  DW  raw load word (lane extraction is done in MEM)
- `bus_req`  out  1  bus request
- `bus_we`  out  1  bus write
- `bus_addr`  out  AW  bus address, `[1:0]` forced to 0
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  DW  lane-replicated store data
- `bus_gnt`  in  1  bus accepted request
- `bus_rvalid`  in  1  bus response; exactly one per accepted request, including writes
- `bus_rdata`  in  DW  bus read data
- `stall_if`  out  1  `if_req` high and no `if_rvalid` this cycle
- `stall_mem`  out  1  `dm_req` high and no `dm_rvalid` this cycle

## Operation
FSM states:
- **IDLE**
  - If either request is high, select one. `x_gnt` is asserted combinationally.
  - The selected address, `we`, `be`, `wdata` and owner are captured at the clock edge.
  - Go to REQ.
- **REQ**
  - `bus_req` = 1 and the bus fields are driven from the captured registers.
  - On `bus_gnt`, go to RSP.
- **RSP**
  - On `bus_rvalid`, pulse the owner's `x_rvalid` combinationally. `x_rdata` = `bus_rdata`.
  - Go to IDLE.

Arbitration and byte enables:
- Fixed priority: data over fetch.
- `bus_be`:
  - word: 1111
  - half: 0011 << (2·`addr[1]`)
  - byte: 0001 << `addr[1:0]`
  - Misalignment is not checked; bits shifted past lane 3 are dropped.
- `bus_wdata`: half replicated to both halves, byte to all four lanes.
- Fetches always use `be` = 1111 and `we` = 0.

Boundary conditions:
- `x_gnt` is only ever asserted in IDLE. A request raised in REQ or RSP waits, with its stall held high.
- Both requests raised in the same IDLE cycle: exactly one grant.
- `bus_rvalid` outside RSP is dropped and produces no `x_rvalid`.
- `bus_gnt` outside REQ is ignored.
- Async reset mid-transaction forces IDLE immediately and deasserts `bus_req`. A late response from that transaction is dropped.

## Timing
- Reset values:
  - state = IDLE, owner = fetch, last-grant = fetch.
  - All captured registers are 0.
  - `bus_req`, `x_gnt`, `x_rvalid` = 0.
- Best-case timing, `x_req` raised in IDLE at cycle 0:
  - `x_gnt` in cycle 0.
  - `bus_req` in cycle 1 (`bus_gnt` same cycle).
  - `bus_rvalid`/`x_rvalid` in cycle 2.
  - IDLE in cycle 3; next grant possible in cycle 3.
- Minimum grant-to-grant interval: 3 cycles.
- Requester rules:
  - Hold `req` and all fields stable until `x_gnt`.
  - Fields may change after the grant edge.
  - `req` may stay high for a following transaction.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both requests are high in IDLE, grant the requester not granted last; last-grant updates on every grant.
- Undefined: fixed data-over-fetch priority; the last-grant register is not built.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE/REQ/RSP)
  - owner encoding (OWN_IF = 0, OWN_DM = 1)
  - size constants SZ_W = 2'b11, SZ_H = 2'b10, SZ_B = 2'b01
- One sub-module, `mem_be_gen`: combinational `size`/`addr[1:0]`/`wdata` → `be`/replicated `wdata`, instantiated once on the selected request.

## Test plan
- Lone fetch: `if_req` = 1, `addr` 0x100, bus `gnt` immediate, `rdata` 0xDEADBEEF at cycle 2 → `if_gnt` at cycle 0, `if_rvalid` at cycle 2 with 0xDEADBEEF, `stall_if` high in cycles 0–1.
- Store byte: `dm_we` = 1, size 01, `addr` 0x203, `wdata` 0x5A → `bus_be` 1000, `bus_wdata` 0x5A5A5A5A, `bus_addr` 0x200; store half at 0x202 → `be` 1100.
- Simultaneous requests, both held for 2 transactions:
  - Fixed priority: data, data, with `stall_if` high throughout.
  - `MEM_ARB_RR_EN`: data then fetch.
- Bus backpressure: `bus_gnt` low for 4 cycles → `bus_req` and fields stable, no second grant, `stall_mem` held.
- Reset in RSP, then `bus_rvalid` pulsed after release → FSM in IDLE, no `x_rvalid`, next request serviced normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // swhb/lwhb size encoding from the controller
    localparam logic [1:0] SZ_W = 2'b11;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_B = 2'b01;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request ports, memory bus, stalls and FSM state of mem_arbiter.
// Handshake: a level x_req is accepted in the cycle x_gnt is high; bus_req holds until bus_gnt; each rvalid is a one-cycle pulse.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                   if_req;
    logic [AW-1:0]          if_addr;
    logic                   if_gnt;
    logic                   if_rvalid;
    logic [DW-1:0]          if_rdata;

    logic                   dm_req;
    logic                   dm_we;
    logic [AW-1:0]          dm_addr;
    logic [1:0]             dm_size;
    logic [DW-1:0]          dm_wdata;
    logic                   dm_gnt;
    logic                   dm_rvalid;
    logic [DW-1:0]          dm_rdata;

    logic                   bus_req;
    logic                   bus_we;
    logic [AW-1:0]          bus_addr;
    logic [3:0]             bus_be;
    logic [DW-1:0]          bus_wdata;
    logic                   bus_gnt;
    logic                   bus_rvalid;
    logic [DW-1:0]          bus_rdata;

    logic                   stall_if;
    logic                   stall_mem;
    mem_arb_pkg::state_t    state;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output stall_if, stall_mem, state
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  stall_if, stall_mem, state
    );

endinterface

// File: rtl/mem_be_gen.sv
// Byte-enable generation and store-data lane replication from size and addr[1:0].
// Misaligned sizes are not checked; enables shifted past lane 3 are dropped.
module mem_be_gen
    import mem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] wdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata_rep
);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_W: be = 4'b1111;
            SZ_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {(DW/16){wdata[15:0]}};
            end
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {(DW/8){wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and load/store share one bus, one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  mif
);

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [DW-1:0] wdata_q;

    logic          sel_dm;
    logic          grant;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_size;
    logic [DW-1:0] sel_wdata;
    logic [3:0]    gen_be;
    logic [DW-1:0] gen_wdata;

`ifdef MEM_ARB_RR_EN
    owner_t last_q;

    // On contention, favour whoever was not granted last
    assign sel_dm = mif.dm_req && (!mif.if_req || (last_q == OWN_IF));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_IF;
        end else if (grant) begin
            last_q <= sel_dm ? OWN_DM : OWN_IF;
        end
    end
`else
    assign sel_dm = mif.dm_req;
`endif

    assign grant     = (state_q == IDLE) && (mif.if_req || mif.dm_req);
    assign sel_addr  = sel_dm ? mif.dm_addr : mif.if_addr;
    assign sel_size  = sel_dm ? mif.dm_size : SZ_W;
    assign sel_wdata = sel_dm ? mif.dm_wdata : '0;

    mem_be_gen #(.DW(DW)) u_be_gen (
        .size      (sel_size),
        .addr_lo   (sel_addr[1:0]),
        .wdata     (sel_wdata),
        .be        (gen_be),
        .wdata_rep (gen_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= sel_dm ? OWN_DM : OWN_IF;
                addr_q  <= sel_addr & ~AW'(3);
                we_q    <= sel_dm && mif.dm_we;
                be_q    <= gen_be;
                wdata_q <= gen_wdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mif.if_gnt    = 1'b0;
        mif.dm_gnt    = 1'b0;
        mif.bus_req   = 1'b0;
        mif.if_rvalid = 1'b0;
        mif.dm_rvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    mif.dm_gnt = sel_dm;
                    mif.if_gnt = !sel_dm;
                    state_d    = REQ;
                end
            end
            REQ: begin
                mif.bus_req = 1'b1;
                if (mif.bus_gnt) state_d = RSP;
            end
            RSP: begin
                // Responses seen in any other state are stale and dropped
                if (mif.bus_rvalid) begin
                    mif.if_rvalid = (owner_q == OWN_IF);
                    mif.dm_rvalid = (owner_q == OWN_DM);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mif.bus_we    = we_q;
    assign mif.bus_addr  = addr_q;
    assign mif.bus_be    = be_q;
    assign mif.bus_wdata = wdata_q;
    assign mif.if_rdata  = mif.bus_rdata;
    assign mif.dm_rdata  = mif.bus_rdata;
    assign mif.stall_if  = mif.if_req && !mif.if_rvalid;
    assign mif.stall_mem = mif.dm_req && !mif.dm_rvalid;
    assign mif.state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard; expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) mif ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];      // {owner is data port, rdata}
    owner_t model_last = OWN_IF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected response
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (mif.if_rvalid === 1'b1 || mif.dm_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b dm_rvalid=%0b, none expected at %0t",
                         mif.if_rvalid, mif.dm_rvalid, $time);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner_data",
                      {30'd0, mif.dm_rvalid, mif.if_rvalid,
                       (mif.dm_rvalid ? mif.dm_rdata : mif.if_rdata)},
                      {30'd0, e[32], ~e[32], e[31:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic owner_t pick();
`ifdef MEM_ARB_RR_EN
        return (model_last == OWN_IF) ? OWN_DM : OWN_IF;
`else
        return OWN_DM;
`endif
    endfunction

    task automatic check_req_phase(input string tag, input logic [31:0] e_addr, input logic e_we,
                                   input logic [3:0] e_be, input logic [31:0] e_wdata);
        check({tag, "_state"},    mif.state, REQ);
        check({tag, "_bus_req"},  mif.bus_req, 1'b1);
        check({tag, "_bus_addr"}, mif.bus_addr, e_addr);
        check({tag, "_bus_we"},   mif.bus_we, e_we);
        check({tag, "_bus_be"},   mif.bus_be, e_be);
        check({tag, "_bus_wdata"}, mif.bus_wdata, e_wdata);
        check({tag, "_no_gnt"},   {mif.if_gnt, mif.dm_gnt}, 2'b00);
        check({tag, "_stall_if"}, mif.stall_if, mif.if_req);
        check({tag, "_stall_mem"}, mif.stall_mem, mif.dm_req);
    endtask

    // Called at posedge+1 in IDLE with requests already driven; returns at posedge+1 of the next IDLE cycle
    task automatic run_txn(input owner_t own, input logic [31:0] e_addr, input logic e_we,
                           input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input logic [31:0] rdata, input int wait_cycles,
                           input bit raise_if, input bit drop_req);
        @(negedge clk);
        check("c0_state", mif.state, IDLE);
        check("c0_if_gnt", mif.if_gnt, own == OWN_IF);
        check("c0_dm_gnt", mif.dm_gnt, own == OWN_DM);
        check("c0_stall_if", mif.stall_if, mif.if_req);
        check("c0_stall_mem", mif.stall_mem, mif.dm_req);
        model_last = own;
        tick();
        if (drop_req) begin
            if (own == OWN_IF) begin
                mif.if_req  = 1'b0;
                mif.if_addr = '1;
            end else begin
                mif.dm_req   = 1'b0;
                mif.dm_addr  = '1;
                mif.dm_wdata = '0;
                mif.dm_size  = 2'b00;
                mif.dm_we    = 1'b0;
            end
        end
        if (raise_if) begin
            mif.if_req  = 1'b1;
            mif.if_addr = 32'h500;
        end
        for (int i = 0; i < wait_cycles; i++) begin
            mif.bus_gnt    = 1'b0;
            mif.bus_rvalid = (i == 1);
            mif.bus_rdata  = 32'hBAD0BAD0;
            @(negedge clk);
            check_req_phase("wait", e_addr, e_we, e_be, e_wdata);
            tick();
        end
        mif.bus_rvalid = 1'b0;
        mif.bus_gnt    = 1'b1;
        @(negedge clk);
        check_req_phase("req", e_addr, e_we, e_be, e_wdata);
        tick();
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b1;
        mif.bus_rdata  = rdata;
        exp_q.push_back({own == OWN_DM, rdata});
        @(negedge clk);
        check("rsp_state", mif.state, RSP);
        check("rsp_no_gnt", {mif.if_gnt, mif.dm_gnt}, 2'b00);
        check("rsp_bus_req", mif.bus_req, 1'b0);
        check("rsp_stall_if", mif.stall_if, (own == OWN_IF) ? 1'b0 : mif.if_req);
        check("rsp_stall_mem", mif.stall_mem, (own == OWN_DM) ? 1'b0 : mif.dm_req);
        tick();
        mif.bus_rvalid = 1'b0;
    endtask

    task automatic set_dm(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
        mif.dm_req   = 1'b1;
        mif.dm_we    = we;
        mif.dm_size  = size;
        mif.dm_addr  = addr;
        mif.dm_wdata = wdata;
    endtask

    initial begin
        owner_t own;
        mif.if_req     = 1'b0;
        mif.if_addr    = '0;
        mif.dm_req     = 1'b0;
        mif.dm_we      = 1'b0;
        mif.dm_addr    = '0;
        mif.dm_size    = 2'b00;
        mif.dm_wdata   = '0;
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b0;
        mif.bus_rdata  = '0;

        // Reset values
        @(negedge clk);
        check("rst_state", mif.state, IDLE);
        check("rst_bus_req", mif.bus_req, 1'b0);
        check("rst_gnt", {mif.if_gnt, mif.dm_gnt}, 2'b00);
        check("rst_rvalid", {mif.if_rvalid, mif.dm_rvalid}, 2'b00);
        check("rst_fields", {mif.bus_we, mif.bus_be, mif.bus_addr}, 37'd0);
        check("rst_wdata", mif.bus_wdata, 32'd0);
        tick();
        reset = 1'b1;

        // Lone fetch, request held until the response
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h100;
        run_txn(OWN_IF, 32'h100, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        mif.if_req = 1'b0;

        // Stray bus_gnt in IDLE is ignored
        mif.bus_gnt = 1'b1;
        @(negedge clk);
        check("idle_gnt_bus_req", mif.bus_req, 1'b0);
        tick();
        mif.bus_gnt = 1'b0;
        @(negedge clk);
        check("idle_gnt_state", mif.state, IDLE);
        tick();

        // Byte enables and lane replication
        set_dm(1'b1, SZ_B, 32'h203, 32'h5A);
        run_txn(OWN_DM, 32'h200, 1'b1, 4'b1000, 32'h5A5A5A5A, 32'h0, 0, 1'b0, 1'b1);
        set_dm(1'b1, SZ_H, 32'h202, 32'h1234);
        run_txn(OWN_DM, 32'h200, 1'b1, 4'b1100, 32'h12341234, 32'h0, 0, 1'b0, 1'b1);
        set_dm(1'b1, SZ_H, 32'h201, 32'hBEEF);
        run_txn(OWN_DM, 32'h200, 1'b1, 4'b0011, 32'hBEEFBEEF, 32'h0, 0, 1'b0, 1'b1);
        set_dm(1'b0, SZ_W, 32'h307, 32'h0);
        run_txn(OWN_DM, 32'h304, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b1);
        set_dm(1'b0, SZ_B, 32'h201, 32'hA7);
        run_txn(OWN_DM, 32'h200, 1'b0, 4'b0010, 32'hA7A7A7A7, 32'h1234A7FF, 0, 1'b0, 1'b1);

        // Both requests held across two transactions
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h400;
        set_dm(1'b0, SZ_W, 32'h800, 32'h0);
        for (int k = 0; k < 2; k++) begin
            own = pick();
            if (own == OWN_IF)
                run_txn(OWN_IF, 32'h400, 1'b0, 4'b1111, 32'h0, 32'h11110000 + k, 0, 1'b0, 1'b0);
            else
                run_txn(OWN_DM, 32'h800, 1'b0, 4'b1111, 32'h0, 32'h22220000 + k, 0, 1'b0, 1'b0);
        end
        mif.if_req = 1'b0;
        mif.dm_req = 1'b0;
        tick();

        // Backpressure with a stray response, and a fetch raised while busy
        set_dm(1'b1, SZ_W, 32'h40C, 32'h11223344);
        run_txn(OWN_DM, 32'h40C, 1'b1, 4'b1111, 32'h11223344, 32'h0, 4, 1'b1, 1'b1);
        run_txn(OWN_IF, 32'h500, 1'b0, 4'b1111, 32'h0, 32'h55AA55AA, 0, 1'b0, 1'b1);

        // Async reset while in RSP, then a late response
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h600;
        @(negedge clk);
        check("abort_if_gnt", mif.if_gnt, 1'b1);
        tick();
        mif.if_req  = 1'b0;
        mif.bus_gnt = 1'b1;
        @(negedge clk);
        check("abort_req_state", mif.state, REQ);
        tick();
        mif.bus_gnt = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_state", mif.state, IDLE);
        check("abort_bus_req", mif.bus_req, 1'b0);
        check("abort_bus_addr", mif.bus_addr, 32'h0);
        model_last = OWN_IF;
        tick();
        reset = 1'b1;
        mif.bus_rvalid = 1'b1;
        mif.bus_rdata  = 32'hBADBAD00;
        @(negedge clk);
        check("late_rsp_rvalid", {mif.if_rvalid, mif.dm_rvalid}, 2'b00);
        check("late_rsp_state", mif.state, IDLE);
        tick();
        mif.bus_rvalid = 1'b0;
        set_dm(1'b0, SZ_W, 32'h700, 32'h0);
        run_txn(OWN_DM, 32'h700, 1'b0, 4'b1111, 32'h0, 32'h77007700, 0, 1'b0, 1'b1);

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
